disp_regctrl_ml: RTL
====================

Name: disp_regctrl_ml

Overview:
- Parametrised multi-layer successor of the display control register block. Serves NLAYER independent display layers from one register bus.
- Each layer has a shadow base address and enable that the CPU writes at any time. The values commit to the active outputs only at the VSYNC falling edge, which gives tear-free page flips.
- Adds a unified W1C interrupt status register with per-source enables, per-layer FIFO under/overflow flags, and a free-running frame counter.

Parameters:
- NLAYER, 2, number of layers, legal range 1..8.
- FCNT_W, 16, frame counter width, legal range 1..32.

Ports:
- ACLK  in  1  system clock.
- ARST_X  in  1  asynchronous active-low reset.
- DSP_VSYNC_X  in  1  active-low VSYNC, asynchronous to ACLK.
- WRADDR  in  16  register write address.
- BYTEEN  in  4  write byte enables.
- WREN  in  1  write strobe.
- WDATA  in  32  write data.
- RDADDR  in  16  register read address.
- RDEN  in  1  read strobe.
- RDATA  out  32  read data, registered.
- DISPON  out  1  global display enable.
- LAYERON  out  NLAYER  active per-layer enables.
- DISPADDR  out  29*NLAYER  active base addresses; layer i occupies bits [29i+28:29i].
- DSP_IRQ  out  1  interrupt, level, registered.
- BUF_UNDER  in  NLAYER  per-layer FIFO underflow pulses.
- BUF_OVER  in  NLAYER  per-layer FIFO overflow pulses.

Behaviour:
- Reset (async assert, sync release):
  - All registers and outputs are 0 and RDATA=0.
  - The 3-bit VSYNC synchroniser resets to 3'b111, so no false edge occurs after reset.
  - A reset mid-operation discards pending commits.
- VSYNC edge: VE = sync[2] & ~sync[1], which is 2–3 ACLK after the DSP_VSYNC_X fall. VE is a single-cycle internal pulse.
- Register map (word addresses, byte enables honoured per byte unless stated):
  - 0x0000 DISPCTRL:
    - bit0 DISPON RW.
    - bit1 VBLANK; VE sets it; writing 1 with BYTEEN[0] clears it.
    - bit2 UPDPEND, read-only.
  - 0x0004 DISPINT: bit0 VBLIE RW, bit1 FIFOIE RW (BYTEEN[0]).
  - 0x0008 INTSTAT, W1C, BYTEEN per byte:
    - bit0 VBL, set by VE.
    - bit[8+i] UNDER_i, set by BUF_UNDER[i].
    - bit[16+i] OVER_i, set by BUF_OVER[i].
  - 0x000C FRAMECNT, read-only. Zero-extended FCNT_W counter, +1 on each VE, wraps to 0.
  - 0x0010+0x10*i LADDR_i, shadow:
    - Bits [28:0] are writable.
    - Bits [31:29] and [1:0] are forced to 0.
  - 0x0014+0x10*i LCTRL_i, shadow, bit0 layer enable.
  - 0x0018+0x10*i LACT_i, read-only. Active address, zero-extended.
  - Unmapped addresses, and layer slots with i >= NLAYER, read 32'hDEADFACE. Writes to them are ignored.
- Commit:
  - Any write to LADDR_i or LCTRL_i sets UPDPEND.
  - On a cycle where VE=1 and UPDPEND=1, all shadows copy to active (DISPADDR, LAYERON) and UPDPEND clears. The update is visible on the next cycle.
  - If DISPON=0, the commit happens on the cycle after the shadow write, with no VSYNC needed.
  - A shadow write on the same cycle as a commit: the commit uses the pre-write shadow value, and UPDPEND stays set. The new value commits at the following VE.
- W1C vs set on the same cycle: set wins (the status bit ends at 1).
- VBLANK and VBL are both set by VE. Each is cleared independently.
- DSP_IRQ is registered, updated every cycle as ((VBL & VBLIE) | (FIFOIE & |UNDER | |OVER)). It is 1 cycle after the status/enable change.
- Read: when RDEN=1, RDATA updates 1 cycle later. When RDEN=0, RDATA holds.
- Reads and writes to the same address in the same cycle: the read returns the pre-write value.

Test Plan:
- Reset then read all regs → DISPCTRL/INTSTAT/FRAMECNT=0. Read 0x0050 with NLAYER=2 → 32'hDEADFACE. DISPADDR=0 and DSP_IRQ=0.
- DISPON=1, write LADDR_1=32'hFFFF_FFFF → shadow reads 32'h1FFF_FFFC and UPDPEND=1. DISPADDR layer1 is unchanged until VE; then it equals 29'h1FFF_FFFC and UPDPEND=0.
- DISPON=0, write LADDR_0=32'h0010_0000 → LACT_0 reads 32'h0010_0000 two cycles later, with no VSYNC.
- Write LADDR_0 on the exact VE cycle → active takes the old value, UPDPEND=1, and the new value appears after the next VSYNC.
- VBLIE=1, one VSYNC → VBL=1, then DSP_IRQ=1 one cycle later. Writing INTSTAT=1 clears it. A W1C coinciding with VE leaves VBL=1.
- FIFOIE=1, pulse BUF_OVER[1] → INTSTAT=32'h0002_0000 and IRQ=1. With FCNT_W=4, 17 VSYNCs → FRAMECNT=1.

Source files
------------

// File: rtl/disp_regctrl_ml.sv
// Multi-layer display control registers: shadowed per-layer base/enable committed at VSYNC fall,
// W1C interrupt status, FIFO error flags and a frame counter. RDATA and DSP_IRQ are registered.
module disp_regctrl_ml #(
  parameter int NLAYER = 2,
  parameter int FCNT_W = 16
) (
  input  logic                  ACLK,
  input  logic                  ARST_X,
  input  logic                  DSP_VSYNC_X,
  input  logic [15:0]           WRADDR,
  input  logic [3:0]            BYTEEN,
  input  logic                  WREN,
  input  logic [31:0]           WDATA,
  input  logic [15:0]           RDADDR,
  input  logic                  RDEN,
  output logic [31:0]           RDATA,
  output logic                  DISPON,
  output logic [NLAYER-1:0]     LAYERON,
  output logic [29*NLAYER-1:0]  DISPADDR,
  output logic                  DSP_IRQ,
  input  logic [NLAYER-1:0]     BUF_UNDER,
  input  logic [NLAYER-1:0]     BUF_OVER
);

  logic [2:0]        vsync_sync;
  logic              ve;
  logic              vblank, updpend, vblie, fifoie, vbl;
  logic [NLAYER-1:0] under, over;
  logic [FCNT_W-1:0] frame_cnt;
  logic [28:0]       sh_addr [NLAYER];
  logic [NLAYER-1:0] sh_on;

  logic              wr_dispctrl, wr_dispint, wr_intstat;
  logic [NLAYER-1:0] wr_laddr, wr_lctrl;
  logic              shadow_wr, commit;
  logic [28:0]       addr_mask;
  logic              vbl_clr;
  logic [NLAYER-1:0] under_clr, over_clr;
  logic [31:0]       intstat, rd_val;
  logic              unused;

  assign unused = ^WDATA;

  // Falling edge of the synchronised VSYNC (stage 2 still high, stage 1 low).
  assign ve = vsync_sync[2] & ~vsync_sync[1];

  assign wr_dispctrl = WREN && (WRADDR == 16'h0000);
  assign wr_dispint  = WREN && (WRADDR == 16'h0004);
  assign wr_intstat  = WREN && (WRADDR == 16'h0008);

  always_comb begin
    wr_laddr = '0;
    wr_lctrl = '0;
    for (int i = 0; i < NLAYER; i++) begin
      wr_laddr[i] = WREN && (WRADDR == 16'(16 + 16 * i));
      wr_lctrl[i] = WREN && (WRADDR == 16'(20 + 16 * i));
    end
  end

  assign shadow_wr = (|wr_laddr) | (|wr_lctrl);
  // With the display off there is no frame to tear, so commit without waiting for VSYNC.
  assign commit    = updpend & (ve | ~DISPON);

  assign addr_mask = {{5{BYTEEN[3]}}, {8{BYTEEN[2]}}, {8{BYTEEN[1]}}, {8{BYTEEN[0]}}};
  assign vbl_clr   = wr_intstat & BYTEEN[0] & WDATA[0];
  assign under_clr = {NLAYER{wr_intstat & BYTEEN[1]}} & WDATA[8 +: NLAYER];
  assign over_clr  = {NLAYER{wr_intstat & BYTEEN[2]}} & WDATA[16 +: NLAYER];

  always_comb begin
    intstat             = '0;
    intstat[0]          = vbl;
    intstat[8 +: NLAYER]  = under;
    intstat[16 +: NLAYER] = over;
  end

  always_comb begin
    rd_val = 32'hDEADFACE;
    case (RDADDR)
      16'h0000: rd_val = {29'b0, updpend, vblank, DISPON};
      16'h0004: rd_val = {30'b0, fifoie, vblie};
      16'h0008: rd_val = intstat;
      16'h000C: rd_val = 32'(frame_cnt);
      default:  rd_val = 32'hDEADFACE;
    endcase
    for (int i = 0; i < NLAYER; i++) begin
      if (RDADDR == 16'(16 + 16 * i)) rd_val = {3'b0, sh_addr[i]};
      if (RDADDR == 16'(20 + 16 * i)) rd_val = {31'b0, sh_on[i]};
      if (RDADDR == 16'(24 + 16 * i)) rd_val = {3'b0, DISPADDR[29*i +: 29]};
    end
  end

  always_ff @(posedge ACLK or negedge ARST_X) begin
    if (!ARST_X) begin
      vsync_sync <= 3'b111;
      DISPON     <= 1'b0;
      vblank     <= 1'b0;
      updpend    <= 1'b0;
      vblie      <= 1'b0;
      fifoie     <= 1'b0;
      vbl        <= 1'b0;
      under      <= '0;
      over       <= '0;
      frame_cnt  <= '0;
      sh_on      <= '0;
      LAYERON    <= '0;
      DISPADDR   <= '0;
      DSP_IRQ    <= 1'b0;
      RDATA      <= '0;
      for (int i = 0; i < NLAYER; i++) sh_addr[i] <= '0;
    end else begin
      vsync_sync <= {vsync_sync[1:0], DSP_VSYNC_X};

      if (wr_dispctrl && BYTEEN[0]) DISPON <= WDATA[0];
      vblank <= ve | (vblank & ~(wr_dispctrl & BYTEEN[0] & WDATA[1]));
      if (wr_dispint && BYTEEN[0]) begin
        vblie  <= WDATA[0];
        fifoie <= WDATA[1];
      end

      // Status sets take priority over a simultaneous W1C.
      vbl   <= ve | (vbl & ~vbl_clr);
      under <= BUF_UNDER | (under & ~under_clr);
      over  <= BUF_OVER  | (over  & ~over_clr);

      if (ve) frame_cnt <= frame_cnt + FCNT_W'(1);

      // Commit samples the shadows before this cycle's write lands; the write re-arms UPDPEND.
      if (commit) begin
        LAYERON <= sh_on;
        for (int i = 0; i < NLAYER; i++) DISPADDR[29*i +: 29] <= sh_addr[i];
      end
      updpend <= shadow_wr | (updpend & ~commit);

      for (int i = 0; i < NLAYER; i++) begin
        if (wr_laddr[i])
          sh_addr[i] <= ((sh_addr[i] & ~addr_mask) | (WDATA[28:0] & addr_mask)) & 29'h1FFF_FFFC;
        if (wr_lctrl[i] && BYTEEN[0]) sh_on[i] <= WDATA[0];
      end

      DSP_IRQ <= (vbl & vblie) | (fifoie & ((|under) | (|over)));

      if (RDEN) RDATA <= rd_val;
    end
  end

endmodule
